// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops IN_W-bit entries from a show-ahead FIFO read port and
// packs LANES consecutive entries into one wide word on a valid/ready output.
// A partial word leaves on an explicit flush or after FLUSH_TO idle cycles,
// with out_keep marking the lanes that hold real entries.
module fifo_word_packer #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned LANES    = 4,
  parameter int unsigned FLUSH_TO = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [IN_W-1:0]       fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*LANES-1:0] out_data,
  output logic [LANES-1:0]      out_keep
);

  localparam int unsigned CW = $clog2(LANES + 1);
  // A disabled timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned IW = (FLUSH_TO > 0) ? $clog2(FLUSH_TO + 1) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((FLUSH_TO > 0) ? FLUSH_TO - 1 : 0);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idle_q;
  logic [IN_W*LANES-1:0]   data_q;
  logic [LANES-1:0]        keep_q;
  logic                    pop;
  logic                    idle_cyc;
  logic                    timeout;

  // Pop qualification and idle-timeout detection.
  always_comb begin
    pop      = (state_q == FILL) && !fifo_empty;
    idle_cyc = (state_q == FILL) && !pop && (cnt_q != '0);
    // Firing on the cycle the counter would reach FLUSH_TO makes the word
    // valid right after the FLUSH_TO-th idle cycle.
    timeout  = (FLUSH_TO > 0) && idle_cyc && (idle_q == IDLE_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave FILL on a full word, a flush with data, or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (pop && ((cnt_q == LAST_LANE) || flush)) begin
          state_d = HOLD;
        end else if (!pop && flush && (cnt_q != '0)) begin
          state_d = HOLD;
        end else if (timeout) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output decode; the pop request is held off while reset is asserted.
  always_comb begin
    fifo_rd_en = pop && rst_n;
    out_valid  = (state_q == HOLD);
    out_data   = data_q;
    out_keep   = keep_q;
  end

  // Lane collection, idle counting, and word clear on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idle_q <= '0;
      data_q <= '0;
      keep_q <= '0;
    end else if (state_q == FILL) begin
      if (pop) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          if (cnt_q == CW'(k)) begin
            data_q[k*IN_W +: IN_W] <= fifo_rd_data;
            keep_q[k]              <= 1'b1;
          end
        end
        cnt_q <= cnt_q + 1'b1;
      end
      if (pop || (state_d == HOLD)) begin
        idle_q <= '0;
      end else if (idle_cyc && (FLUSH_TO > 0)) begin
        idle_q <= idle_q + 1'b1;
      end
    end else if (out_ready) begin
      cnt_q  <= '0;
      data_q <= '0;
      keep_q <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: a queue-based FIFO model feeds the DUT, pushed
// bytes form the expected stream, and a monitor checks every accepted word.
module tb_fifo_word_packer;

  localparam int unsigned IN_W     = 8;
  localparam int unsigned LANES    = 4;
  localparam int unsigned FLUSH_TO = 16;
  localparam int unsigned DW       = IN_W * LANES;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [IN_W-1:0] fifo_rd_data = '0;
  logic            fifo_rd_en;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [LANES-1:0] out_keep;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  logic [IN_W-1:0]  fq[$];
  logic [IN_W-1:0]  exp_bytes[$];
  logic [DW-1:0]    exp_data[$];
  logic [LANES-1:0] exp_keep[$];
  bit               directed = 1'b1;
  bit               pop_pending = 1'b0;
  bit               empty_at_sample = 1'b1;

  fifo_word_packer #(
    .IN_W    (IN_W),
    .LANES   (LANES),
    .FLUSH_TO(FLUSH_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_keep    (out_keep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event occurred, required not to", name);
  endtask

  task automatic push(input logic [IN_W-1:0] b);
    fq.push_back(b);
    exp_bytes.push_back(b);
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic [LANES-1:0] k);
    exp_data.push_back(d);
    exp_keep.push_back(k);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (exp_data.size() == 0) break;
      @(negedge clk);
    end
    if (exp_data.size() != 0) begin
      fail_now("drain_timeout");
      exp_data.delete();
      exp_keep.delete();
    end
  endtask

  // FIFO model: retire the pop seen at the last posedge, then present the head.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        check("pop_nonempty", empty_at_sample, 0);
        if (fq.size() > 0) void'(fq.pop_front());
      end
      #1;
      fifo_empty   = (fq.size() == 0);
      fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
      #1;
      pop_pending     = fifo_rd_en;
      empty_at_sample = fifo_empty;
    end
  end

  // Monitor: checks hold stability and every accepted word against the scoreboard.
  initial begin
    bit              held;
    logic [DW-1:0]   hd;
    logic [LANES-1:0] hk;
    logic [IN_W-1:0] lane;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_keep", out_keep, hk);
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        held = 1'b1;
        hd   = out_data;
        hk   = out_keep;
      end
      if (out_valid && out_ready) begin
        check("keep_shape", ((({28'd0, out_keep} & ({28'd0, out_keep} + 32'd1)) == 0) && (out_keep != 0)), 1);
        for (int k = 0; k < LANES; k++) begin
          lane = out_data[k*IN_W +: IN_W];
          if (out_keep[k]) begin
            if (exp_bytes.size() == 0) fail_now("extra_byte");
            else check("stream_byte", lane, exp_bytes.pop_front());
          end else begin
            check("unused_lane_zero", lane, 0);
          end
        end
        if (exp_data.size() > 0) begin
          check("word_data", out_data, exp_data.pop_front());
          check("word_keep", out_keep, exp_keep.pop_front());
        end else if (directed) begin
          fail_now("unexpected_word");
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized stream.
  initial begin
    int unsigned pushed;
    int unsigned cycles;

    // Reset state
    tick(2);
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_keep", out_keep, 0);
    check("rst_data", out_data, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Two full words back to back
    out_ready = 1'b1;
    expect_word(32'h03020100, 4'hF);
    expect_word(32'h07060504, 4'hF);
    for (int unsigned b = 0; b < 8; b++) begin
      push(IN_W'(b));
      tick(1);
    end
    wait_drain(60);
    tick(2);

    // Explicit flush of a partial word, then a flush with nothing collected
    expect_word(32'h00002211, 4'h3);
    push(8'h11);
    tick(1);
    push(8'h22);
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain(20);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      #3;
      check("no_empty_word", out_valid, 0);
      tick(1);
    end

    // Idle timeout on a single entry
    out_ready = 1'b0;
    expect_word(32'h000000AB, 4'h1);
    push(8'hAB);
    for (int unsigned k = 1; k <= 17; k++) begin
      tick(1);
      #3;
      if (k == 16) check("timeout_early", out_valid, 0);
      if (k == 17) check("timeout_fire", out_valid, 1);
    end
    tick(1);
    out_ready = 1'b1;
    wait_drain(20);
    tick(2);

    // Back-pressure: word held, FIFO keeps the rest
    out_ready = 1'b0;
    expect_word(32'h44434241, 4'hF);
    expect_word(32'h00004645, 4'h3);
    for (int unsigned b = 0; b < 6; b++) begin
      push(8'h41 + 8'(b));
      tick(1);
    end
    tick(3);
    for (int unsigned i = 0; i < 10; i++) begin
      #3;
      check("bp_valid", out_valid, 1);
      check("bp_rd_en", fifo_rd_en, 0);
      check("bp_fifo_kept", fq.size(), 2);
      tick(1);
    end
    out_ready = 1'b1;
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain(20);
    tick(2);

    // Reset mid-word discards the collected lanes
    push(8'h51);
    tick(1);
    push(8'h52);
    tick(3);
    rst_n = 1'b0;
    push(8'h60);
    #3;
    check("midrst_valid", out_valid, 0);
    check("midrst_keep", out_keep, 0);
    check("midrst_data", out_data, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    void'(exp_bytes.pop_front());
    void'(exp_bytes.pop_front());
    expect_word(32'h63626160, 4'hF);
    tick(2);
    rst_n = 1'b1;
    push(8'h61);
    tick(1);
    push(8'h62);
    tick(1);
    push(8'h63);
    tick(1);
    wait_drain(30);
    tick(2);

    // Randomized stream with random back-pressure and flushes
    directed = 1'b0;
    pushed = 0;
    cycles = 0;
    while (pushed < 200 && cycles < 5000) begin
      if ($urandom_range(0, 1) == 1) begin
        push(IN_W'($urandom()));
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      tick(1);
      cycles++;
    end
    flush = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 600; i++) begin
      if (fq.size() == 0 && exp_bytes.size() == 0) break;
      tick(1);
    end
    check("rand_stream_drained", exp_bytes.size(), 0);
    check("rand_fifo_drained", fq.size(), 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
